// File: rtl/weight_loader.sv
// Transmit side of the PE weight-load interface: shifts one tile of ROWS Q8.8
// weights down a PE column on the broadcast accept strobe, then requests a switch.
module weight_loader #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] col_weight_out,
    output logic              col_accept_w_out,
    output logic              switch_req,
    input  logic              switch_ack,
    output logic              busy,
    output logic              tile_done,
    output logic [CNT_W-1:0]  tiles_loaded
);

    localparam int CW = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        LAST = 2'd2,
        PEND = 2'd3
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            cnt_q;
    logic                     w_ready_q;
    logic signed [DATA_W-1:0] weight_q;
    logic                     accept_q;
    logic                     switch_req_q;
    logic                     busy_q;
    logic                     tile_done_q;
    logic [CNT_W-1:0]         tiles_q;
    logic                     fire;

    assign fire = w_valid & w_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            w_ready_q    <= 1'b0;
            weight_q     <= '0;
            accept_q     <= 1'b0;
            switch_req_q <= 1'b0;
            busy_q       <= 1'b0;
            tile_done_q  <= 1'b0;
            tiles_q      <= '0;
        end else begin
            // Bus and strobe default to idle each cycle; a stall leaves the column untouched.
            weight_q    <= '0;
            accept_q    <= 1'b0;
            tile_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= LOAD;
                        cnt_q     <= '0;
                        w_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (fire) begin
                        weight_q <= w_data;
                        accept_q <= 1'b1;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            state_q   <= LAST;
                            w_ready_q <= 1'b0;
                        end
                    end
                end
                LAST: begin
                    // Final weight is on the bus now; request the switch only after it lands.
                    state_q      <= PEND;
                    switch_req_q <= 1'b1;
                end
                PEND: begin
                    if (switch_ack) begin
                        tile_done_q  <= 1'b1;
                        tiles_q      <= tiles_q + 1'b1;
                        switch_req_q <= 1'b0;
                        if (start) begin
                            state_q   <= LOAD;
                            cnt_q     <= '0;
                            w_ready_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    w_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign w_ready          = w_ready_q;
    assign col_weight_out   = weight_q;
    assign col_accept_w_out = accept_q;
    assign switch_req       = switch_req_q;
    assign busy             = busy_q;
    assign tile_done        = tile_done_q;
    assign tiles_loaded     = tiles_q;

endmodule
